atb_funnel_2to1: RTL

ATB_FUNNEL_2TO1 -- requirements
Module: atb_funnel_2to1

---
 rtl/atb_funnel_2to1_if.sv | 91 +++++++++
 rtl/atb_funnel_2to1.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/atb_funnel_2to1_if.sv
// ---------------------------------------------------------------------------
// atb_funnel_2to1_if
//
// Bundles every ATB signal around the 2:1 funnel: two upstream trace source
// ports (s_*) and one downstream trace sink port (m_*).
//
// Parameters
//   DATA_W : trace data width per port
//   ID_W   : trace source ID width
//
// Signals (named from the funnel's point of view)
//   s_atvalid/s_atready/s_atdata/s_atbytes/s_atid : upstream transfers, port i
//                                                   in bit i / slice i
//   s_afvalid/s_afready                           : flush request to sources
//   s_syncreq, s_atwakeup                         : sync broadcast, wake-up
//   m_atvalid/m_atready/m_atdata/m_atbytes/m_atid : downstream transfer
//   m_afvalid/m_afready                           : downstream flush handshake
//   m_syncreq, m_atwakeup                         : sync in, wake-up out
//
// Modports
//   master : the funnel itself
//   slave  : the environment (sources plus sink) around the funnel
// ---------------------------------------------------------------------------
interface atb_funnel_2to1_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 7
);

    logic [1:0]          s_atvalid;
    logic [1:0]          s_atready;
    logic [2*DATA_W-1:0] s_atdata;
    logic [3:0]          s_atbytes;
    logic [2*ID_W-1:0]   s_atid;
    logic [1:0]          s_afvalid;
    logic [1:0]          s_afready;
    logic [1:0]          s_syncreq;
    logic [1:0]          s_atwakeup;

    logic                m_atvalid;
    logic                m_atready;
    logic [DATA_W-1:0]   m_atdata;
    logic [1:0]          m_atbytes;
    logic [ID_W-1:0]     m_atid;
    logic                m_afvalid;
    logic                m_afready;
    logic                m_syncreq;
    logic                m_atwakeup;

    modport master (
        input  s_atvalid,
        output s_atready,
        input  s_atdata,
        input  s_atbytes,
        input  s_atid,
        output s_afvalid,
        input  s_afready,
        output s_syncreq,
        input  s_atwakeup,
        output m_atvalid,
        input  m_atready,
        output m_atdata,
        output m_atbytes,
        output m_atid,
        input  m_afvalid,
        output m_afready,
        input  m_syncreq,
        output m_atwakeup
    );

    modport slave (
        output s_atvalid,
        input  s_atready,
        output s_atdata,
        output s_atbytes,
        output s_atid,
        input  s_afvalid,
        output s_afready,
        input  s_syncreq,
        output s_atwakeup,
        input  m_atvalid,
        output m_atready,
        input  m_atdata,
        input  m_atbytes,
        input  m_atid,
        output m_afvalid,
        input  m_afready,
        output m_syncreq,
        input  m_atwakeup
    );

endinterface

// File: rtl/atb_funnel_2to1.sv
// ---------------------------------------------------------------------------
// atb_funnel_2to1
//
// Two-input ATB trace funnel. Transfers from two source ports are merged
// round-robin into a single registered output stage (one cycle latency,
// full throughput). A flush request from downstream is fanned out to both
// sources; it is acknowledged once both sources completed their flush and
// the output register has drained.
//
// Parameters
//   DATA_W : trace data width per port (must match the interface)
//   ID_W   : trace source ID width (must match the interface)
//
// Ports
//   atclk    : sole clock, rising edge
//   atresetn : asynchronous active-low reset
//   atclken  : clock enable, qualifies every state update
//   bus      : all ATB signals (see atb_funnel_2to1_if), master view
// ---------------------------------------------------------------------------
module atb_funnel_2to1 #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 7
) (
    input  logic                  atclk,
    input  logic                  atresetn,
    input  logic                  atclken,
    atb_funnel_2to1_if.master     bus
);

    // Flush sequencer states
    localparam logic [1:0] F_IDLE   = 2'd0;
    localparam logic [1:0] F_ACTIVE = 2'd1;
    localparam logic [1:0] F_DONE   = 2'd2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [1:0]        bytes_q, bytes_d;
    logic [ID_W-1:0]   id_q,    id_d;
    logic              rr_q,    rr_d;
    logic [1:0]        fstate_q, fstate_d;
    logic [1:0]        done_q,   done_d;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic       out_free;
    logic [1:0] grant;
    logic [1:0] ready;
    logic [1:0] accept;
    logic       sel;

    // The output stage can take a new beat when empty or draining this cycle.
    assign out_free = !valid_q || bus.m_atready;

    // rr only matters on contention; a lone requester always wins.
    always_comb begin
        if (bus.s_atvalid == 2'b11) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end else begin
            grant = bus.s_atvalid;
        end
    end

    assign ready         = grant & {2{out_free && atclken}};
    assign bus.s_atready = ready;
    assign accept        = bus.s_atvalid & ready;
    assign sel           = accept[1];

    // -----------------------------------------------------------------------
    // Output register next state
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        id_d    = id_q;
        rr_d    = rr_q;
        if (atclken) begin
            if (|accept) begin
                valid_d = 1'b1;
                data_d  = sel ? bus.s_atdata[DATA_W +: DATA_W] : bus.s_atdata[0 +: DATA_W];
                bytes_d = sel ? bus.s_atbytes[2 +: 2] : bus.s_atbytes[0 +: 2];
                id_d    = sel ? bus.s_atid[ID_W +: ID_W] : bus.s_atid[0 +: ID_W];
                // Prefer the other port next time.
                rr_d    = accept[0];
            end else if (bus.m_atready) begin
                valid_d = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Flush sequencer
    // -----------------------------------------------------------------------
    logic [1:0] af_valid;
    logic       af_ready;

    always_comb begin
        fstate_d = fstate_q;
        done_d   = done_q;
        af_valid = 2'b00;
        af_ready = 1'b0;
        unique case (fstate_q)
            F_IDLE: begin
                if (atclken && bus.m_afvalid) begin
                    fstate_d = F_ACTIVE;
                    done_d   = 2'b00;
                end
            end
            F_ACTIVE: begin
                af_valid = ~done_q;
                if (atclken) begin
                    done_d = done_q | (af_valid & bus.s_afready);
                    // Sources flushed is not enough: the buffered beat must
                    // also have left before the flush is complete.
                    if (done_q == 2'b11 && !valid_q) begin
                        fstate_d = F_DONE;
                    end
                end
            end
            F_DONE: begin
                af_ready = 1'b1;
                if (atclken) begin
                    fstate_d = F_IDLE;
                end
            end
            default: begin
                fstate_d = F_IDLE;
            end
        endcase
    end

    assign bus.s_afvalid = af_valid;
    assign bus.m_afready = af_ready;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge atclk or negedge atresetn) begin
        if (!atresetn) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            bytes_q  <= '0;
            id_q     <= '0;
            rr_q     <= 1'b0;
            fstate_q <= F_IDLE;
            done_q   <= 2'b00;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            bytes_q  <= bytes_d;
            id_q     <= id_d;
            rr_q     <= rr_d;
            fstate_q <= fstate_d;
            done_q   <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.m_atvalid  = valid_q;
    assign bus.m_atdata   = data_q;
    assign bus.m_atbytes  = bytes_q;
    assign bus.m_atid     = id_q;
    assign bus.s_syncreq  = {2{bus.m_syncreq}};
    assign bus.m_atwakeup = (|bus.s_atwakeup) || (|bus.s_atvalid) || valid_q;

endmodule
